// File: rtl/alu_bist.sv
// Built-in self-test controller for a 32-bit ALU: replays a fixed 21-entry
// vector table into the ALU and reports pass/fail, error count and first failure.
module alu_bist #(
  parameter int WIDTH   = 32,
  parameter int NUM_VEC = 21,
  parameter int IDXW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] aluout,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDXW-1:0]  err_count,
  output logic [IDXW-1:0]  first_fail_idx
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] r,
                              input logic z);
    return {op, a, b, r, z};
  endfunction

  // Vector ROM; SLT entries probe the signed compare around the sign boundary.
  function automatic vec_t table_entry(input logic [IDXW-1:0] i);
    case (int'(i))
      0:       return mk(OP_ADD, 32'h0,        32'h0,        32'h0,        1'b1);
      1:       return mk(OP_ADD, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      2:       return mk(OP_ADD, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1);
      3:       return mk(OP_ADD, 32'hFF,       32'h1,        32'h100,      1'b0);
      4:       return mk(OP_SUB, 32'h0,        32'h0,        32'h0,        1'b1);
      5:       return mk(OP_SUB, 32'h0,        32'hFFFFFFFF, 32'h1,        1'b0);
      6:       return mk(OP_SUB, 32'h1,        32'h1,        32'h0,        1'b1);
      7:       return mk(OP_SUB, 32'h100,      32'h1,        32'hFF,       1'b0);
      8:       return mk(OP_SLT, 32'h0,        32'h0,        32'h0,        1'b1);
      9:       return mk(OP_SLT, 32'h0,        32'h1,        32'h1,        1'b0);
      10:      return mk(OP_SLT, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1);
      11:      return mk(OP_SLT, 32'h1,        32'h0,        32'h0,        1'b1);
      12:      return mk(OP_SLT, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0);
      13:      return mk(OP_AND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      14:      return mk(OP_AND, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0);
      15:      return mk(OP_AND, 32'h12345678, 32'h87654321, 32'h02244220, 1'b0);
      16:      return mk(OP_AND, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1);
      17:      return mk(OP_OR,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      18:      return mk(OP_OR,  32'h12345678, 32'h87654321, 32'h97755779, 1'b0);
      19:      return mk(OP_OR,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
      20:      return mk(OP_OR,  32'h0,        32'h0,        32'h0,        1'b1);
      default: return mk(OP_AND, 32'h0,        32'h0,        32'h0,        1'b1);
    endcase
  endfunction

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  srca_q, srcb_q, exp_res_q;
  logic [2:0]        op_q;
  logic              exp_zero_q;
  logic              busy_q, done_q, pass_q;
  logic [IDXW-1:0]   err_q, ff_q;

  vec_t              vec;
  logic              mismatch;
  logic              last;
  logic [IDXW-1:0]   err_d;

  assign vec      = table_entry(idx_q);
  assign mismatch = (aluout != exp_res_q) || (zero != exp_zero_q);
  assign last     = (idx_q == IDXW'(NUM_VEC - 1));
  // Error counter saturates so a long faulty table can never wrap back to zero.
  assign err_d    = (mismatch && (err_q != '1)) ? err_q + IDXW'(1) : err_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      srca_q     <= '0;
      srcb_q     <= '0;
      op_q       <= '0;
      exp_res_q  <= '0;
      exp_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ff_q       <= '1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            ff_q    <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          srca_q     <= WIDTH'(vec.a);
          srcb_q     <= WIDTH'(vec.b);
          op_q       <= vec.op;
          exp_res_q  <= WIDTH'(vec.res);
          exp_zero_q <= vec.z;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= err_d;
          if (mismatch && (err_q == '0)) ff_q <= idx_q;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + IDXW'(1);
            state_q <= S_APPLY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign srca           = srca_q;
  assign srcb           = srcb_q;
  assign alucontrol     = op_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: attaches a good or fault-injected ALU
// stub and compares the controller against a run-level behavioural model.
module tb_alu_bist;

  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] srca, srcb, aluout;
  logic [2:0]  alucontrol;
  logic        zero;
  logic        busy, done, pass;
  logic [4:0]  err_count, first_fail_idx;

  int fault_mode = 0;  // 0 good ALU, 1 SLT compares unsigned, 2 zero stuck at 0
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_bist dut (
    .clk(clk), .reset(reset), .start(start),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
    .aluout(aluout), .zero(zero),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } tv_t;

  tv_t tab [NV] = '{
    '{3'b010, 32'h0,        32'h0,        32'h0,        1'b1},
    '{3'b010, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
    '{3'b010, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b1},
    '{3'b010, 32'hFF,       32'h1,        32'h100,      1'b0},
    '{3'b110, 32'h0,        32'h0,        32'h0,        1'b1},
    '{3'b110, 32'h0,        32'hFFFFFFFF, 32'h1,        1'b0},
    '{3'b110, 32'h1,        32'h1,        32'h0,        1'b1},
    '{3'b110, 32'h100,      32'h1,        32'hFF,       1'b0},
    '{3'b111, 32'h0,        32'h0,        32'h0,        1'b1},
    '{3'b111, 32'h0,        32'h1,        32'h1,        1'b0},
    '{3'b111, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1},
    '{3'b111, 32'h1,        32'h0,        32'h0,        1'b1},
    '{3'b111, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0},
    '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
    '{3'b000, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0},
    '{3'b000, 32'h12345678, 32'h87654321, 32'h02244220, 1'b0},
    '{3'b000, 32'h0,        32'hFFFFFFFF, 32'h0,        1'b1},
    '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
    '{3'b001, 32'h12345678, 32'h87654321, 32'h97755779, 1'b0},
    '{3'b001, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},
    '{3'b001, 32'h0,        32'h0,        32'h0,        1'b1}
  };

  // ALU stub, optionally faulty; returns {zero, result}.
  function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int mode);
    logic [31:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = (mode == 1) ? {31'b0, a < b} : {31'b0, $signed(a) < $signed(b)};
      default: r = 32'h0;
    endcase
    return {(mode == 2) ? 1'b0 : (r == 32'h0), r};
  endfunction

  assign {zero, aluout} = alu_f(alucontrol, srca, srcb, fault_mode);

  // Whole-run prediction: which table entries the attached ALU gets wrong.
  task automatic predict(input int mode, output int e, output logic [4:0] ff);
    logic [32:0] got;
    e = 0;
    ff = 5'h1F;
    for (int i = 0; i < NV; i++) begin
      got = alu_f(tab[i].op, tab[i].a, tab[i].b, mode);
      if (got != {tab[i].z, tab[i].r}) begin
        if (e == 0) ff = 5'(i);
        if (e < 31) e++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level model: a run is 2*NV edges after the accepted start; operands
  // show table[k] from edge 2k+1 onwards; results appear at the final edge.
  bit          m_active = 0, m_done = 0, m_pass = 0;
  int          m_n = 0, t_err = 0;
  logic [4:0]  m_err = 0, m_ff = 5'h1F, t_ff = 5'h1F;
  logic [31:0] m_a = 0, m_b = 0;
  logic [2:0]  m_op = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0; m_done = 0; m_pass = 0; m_n = 0;
      m_err = 0; m_ff = 5'h1F; m_a = 0; m_b = 0; m_op = 0;
    end else if (m_active) begin
      m_n++;
      if (m_n % 2 == 1) begin
        m_a  = tab[(m_n - 1) / 2].a;
        m_b  = tab[(m_n - 1) / 2].b;
        m_op = tab[(m_n - 1) / 2].op;
      end
      if (m_n == 2 * NV) begin
        m_active = 0; m_done = 1;
        m_err = 5'(t_err); m_ff = t_ff; m_pass = (t_err == 0);
      end
    end else if (start) begin
      m_active = 1; m_n = 0; m_done = 0; m_pass = 0;
      m_err = 0; m_ff = 5'h1F;
      predict(fault_mode, t_err, t_ff);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
      check("pass", 32'(pass), 32'(m_pass));
      check("srca", srca, m_a);
      check("srcb", srcb, m_b);
      check("alucontrol", 32'(alucontrol), 32'(m_op));
      if (!m_active) begin
        check("err_count", 32'(err_count), 32'(m_err));
        check("first_fail_idx", 32'(first_fail_idx), 32'(m_ff));
      end
    end
  end

  // Called at a negedge; start is high across exactly one rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic check_results(input string tag, input logic p, input int e, input int ff);
    check({tag, "_pass"}, 32'(pass), 32'(p));
    check({tag, "_err"}, 32'(err_count), 32'(e));
    check({tag, "_ffi"}, 32'(first_fail_idx), 32'(ff));
    check({tag, "_model_err"}, 32'(t_err), 32'(e));
  endtask

  int lat;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ffi", 32'(first_fail_idx), 32'h1F);
    check("rst_err", 32'(err_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Good ALU: 42-cycle run, last vector left on the operand bus.
    pulse_start();
    wait_done(lat);
    check("good_latency", 32'(lat), 32'd42);
    check_results("good", 1'b1, 0, 5'h1F);
    check("good_srca", srca, 32'h0);
    check("good_srcb", srcb, 32'h0);
    check("good_op", 32'(alucontrol), 32'b001);

    // Unsigned SLT fault: vectors 10 and 12 fail.
    fault_mode = 1;
    pulse_start();
    check("restart_done_drop", 32'(done), 32'd0);
    wait_done(lat);
    check_results("slt", 1'b0, 2, 10);

    // Zero stuck low: every entry expecting zero=1 fails.
    fault_mode = 2;
    pulse_start();
    wait_done(lat);
    check_results("zero", 1'b0, 9, 0);

    // Start during a run is ignored; the run still ends at E0+42.
    fault_mode = 0;
    pulse_start();
    repeat (9) @(negedge clk);
    pulse_start();
    wait_done(lat);
    check("ignore_latency", 32'(lat + 10), 32'd42);
    check_results("ignore", 1'b1, 0, 5'h1F);
    pulse_start();
    check("rerun_done_drop", 32'(done), 32'd0);
    wait_done(lat);
    check_results("rerun", 1'b1, 0, 5'h1F);

    // Reset during vector 7 CHECK discards the run.
    pulse_start();
    repeat (15) @(negedge clk);
    check("v7_srca", srca, 32'h100);
    check("v7_op", 32'(alucontrol), 32'b110);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_srca", srca, 32'h0);
    check("midrst_ffi", 32'(first_fail_idx), 32'h1F);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    wait_done(lat);
    check("post_rst_latency", 32'(lat), 32'd42);
    check_results("post_rst", 1'b1, 0, 5'h1F);

    // Operand probe at vector 15 CHECK.
    pulse_start();
    repeat (31) @(negedge clk);
    check("v15_srca", srca, 32'h12345678);
    check("v15_srcb", srcb, 32'h87654321);
    check("v15_op", 32'(alucontrol), 32'b000);
    check("v15_aluout", aluout, 32'h02244220);
    wait_done(lat);
    check_results("probe", 1'b1, 0, 5'h1F);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
